// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks destination tags from EX through WB,
// selects per-operand forwarding sources for EX and stalls ID/IF on load-use hazards.
module forwarding_hazard_unit #(
    parameter int REG_W          = 5,
    parameter int N_SRC          = 2,
    parameter int DEPTH          = 3,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int CNT_W          = 16,
    localparam int FSW           = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [N_SRC*REG_W-1:0] id_rs,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   flush,
    output logic                   stall,
    output logic [N_SRC*FSW-1:0]   fwd_sel,
    output logic [CNT_W-1:0]       stall_count
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] regwrite_reg;
    logic [DEPTH-2:0] memread_reg;    // the oldest stage's load flag is never consulted
    logic [REG_W-1:0] rd_reg [DEPTH];
    logic [REG_W-1:0] src_reg [N_SRC];
    logic [CNT_W-1:0] count_reg;

    logic [REG_W-1:0] id_src [N_SRC];
    logic [FSW-1:0]   sel_next [N_SRC];
    logic [N_SRC-1:0] hazard_vec;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign id_src[gi] = id_rs[gi*REG_W +: REG_W];
            assign fwd_sel[gi*FSW +: FSW] = sel_next[gi];

            // Walk from oldest to youngest so the youngest producer wins.
            always_comb begin
                sel_next[gi] = '0;
                if (valid_reg[0]) begin
                    for (int k = DEPTH - 1; k >= 1; k--) begin
                        if (valid_reg[k] && regwrite_reg[k] &&
                            rd_reg[k] == src_reg[gi] && src_reg[gi] != '0) begin
                            sel_next[gi] = FSW'(k);
                        end
                    end
                end
            end

            always_comb begin
                hazard_vec[gi] = 1'b0;
                for (int j = DEPTH - 2; j >= 0; j--) begin
                    if (valid_reg[j] && regwrite_reg[j] &&
                        rd_reg[j] == id_src[gi] && id_src[gi] != '0) begin
                        hazard_vec[gi] = memread_reg[j] && (j + 1 < LOAD_FWD_STAGE);
                    end
                end
            end
        end
    endgenerate

    assign stall       = id_valid & (|hazard_vec) & ~flush & ~rst;
    assign stall_count = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= '0;
            regwrite_reg <= '0;
            memread_reg  <= '0;
            count_reg    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_reg[k] <= '0;
            end
            for (int i = 0; i < N_SRC; i++) begin
                src_reg[i] <= '0;
            end
        end else begin
            valid_reg[0]    <= id_valid & ~stall & ~flush;
            regwrite_reg[0] <= id_regwrite;
            memread_reg[0]  <= id_memread;
            rd_reg[0]       <= id_rd;
            for (int i = 0; i < N_SRC; i++) begin
                src_reg[i] <= id_src[i];
            end
            for (int k = 1; k < DEPTH; k++) begin
                valid_reg[k]    <= valid_reg[k-1];
                regwrite_reg[k] <= regwrite_reg[k-1];
                rd_reg[k]       <= rd_reg[k-1];
            end
            for (int k = 1; k < DEPTH - 1; k++) begin
                memread_reg[k] <= memread_reg[k-1];
            end
            if (stall && count_reg != '1) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: default configuration plus a
// wider/deeper instance with a narrow saturating stall counter.
module tb_forwarding_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance: REG_W=5, N_SRC=2, DEPTH=3, LOAD_FWD_STAGE=2
    logic        d_valid, d_rw, d_mr, d_flush;
    logic [9:0]  d_rs;
    logic [4:0]  d_rd;
    logic        d_stall;
    logic [3:0]  d_fwd;
    logic [15:0] d_count;

    // sweep instance: N_SRC=3, DEPTH=4, LOAD_FWD_STAGE=3, CNT_W=2
    logic        w_valid, w_rw, w_mr, w_flush;
    logic [14:0] w_rs;
    logic [4:0]  w_rd;
    logic        w_stall;
    logic [5:0]  w_fwd;
    logic [1:0]  w_count;

    int checks = 0;
    int failures = 0;

    forwarding_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(d_valid), .id_rs(d_rs), .id_rd(d_rd),
        .id_regwrite(d_rw), .id_memread(d_mr), .flush(d_flush),
        .stall(d_stall), .fwd_sel(d_fwd), .stall_count(d_count)
    );

    forwarding_hazard_unit #(
        .REG_W(5), .N_SRC(3), .DEPTH(4), .LOAD_FWD_STAGE(3), .CNT_W(2)
    ) dut_w (
        .clk(clk), .rst(rst), .id_valid(w_valid), .id_rs(w_rs), .id_rd(w_rd),
        .id_regwrite(w_rw), .id_memread(w_mr), .flush(w_flush),
        .stall(w_stall), .fwd_sel(w_fwd), .stall_count(w_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic rw, input logic mr);
        d_valid = v; d_rs = {rs1, rs0}; d_rd = rd; d_rw = rw; d_mr = mr;
    endtask

    task automatic set_w(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        w_valid = v; w_rs = {rs2, rs1, rs0}; w_rd = rd; w_rw = rw; w_mr = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        d_flush = 1'b0;
        w_flush = 1'b0;
        // reset with a valid, self-dependent load presented in ID
        set_d(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
        set_w(1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        sample();
        check_eq("rst1_stall", d_stall, 0);
        check_eq("rst1_fwd", d_fwd, 0);
        check_eq("rst1_count", d_count, 0);
        tick();
        sample();
        check_eq("rst2_stall", d_stall, 0);
        check_eq("rst2_fwd", d_fwd, 0);
        check_eq("w_rst_stall", w_stall, 0);
        check_eq("w_rst_count", w_count, 0);
        tick();
        rst = 1'b0;
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        set_w(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        sample();
        check_eq("post_rst_stall", d_stall, 0);
        check_eq("post_rst_fwd", d_fwd, 0);
        check_eq("post_rst_count", d_count, 0);

        // ALU chain, adjacent: add x5 ; sub x6,x5,x5
        tick();
        set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        sample();
        check_eq("alu_adj_nostall", d_stall, 0);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("alu_adj_fwd", d_fwd, 4'b0101);

        // ALU chain with one unrelated instruction between
        tick();
        set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd10, 5'd11, 5'd9, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("alu_gap_fwd", d_fwd, 4'b1010);

        // two writers of x7, youngest wins; operand1 reads x0
        tick();
        set_d(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("prio_fwd", d_fwd, 4'b0001);

        // load-use adjacent: lw x3 ; add x10,x3,x4
        tick(); tick(); tick();
        set_d(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        sample();
        check_eq("lw_issue_nostall", d_stall, 0);
        tick();
        set_d(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
        sample();
        check_eq("lu_stall", d_stall, 1);
        check_eq("lu_count_before", d_count, 0);
        tick();
        sample();
        check_eq("lu_stall_release", d_stall, 0);
        check_eq("lu_bubble_fwd", d_fwd, 0);
        check_eq("lu_count", d_count, 1);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("lu_fwd", d_fwd, 4'b0010);
        check_eq("lu_count_hold", d_count, 1);

        // load two slots ahead of the consumer: no stall, forward from S2
        tick();
        set_d(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_d(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd3, 5'd3, 5'd10, 1'b1, 1'b0);
        sample();
        check_eq("lu_gap_nostall", d_stall, 0);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("lu_gap_fwd", d_fwd, 4'b1010);

        // load into x0 followed by a reader of x0
        tick(); tick(); tick();
        set_d(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
        sample();
        check_eq("x0_nostall", d_stall, 0);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("x0_fwd", d_fwd, 0);

        // flush in the hazard cycle wins over stall
        tick();
        set_d(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_d(1'b1, 5'd3, 5'd3, 5'd10, 1'b1, 1'b0);
        d_flush = 1'b1;
        sample();
        check_eq("flush_nostall", d_stall, 0);
        tick();
        d_flush = 1'b0;
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("flush_s0_bubble_fwd", d_fwd, 0);
        check_eq("flush_count", d_count, 1);

        // reset arriving mid-stall clears everything at that edge
        tick(); tick();
        set_d(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_d(1'b1, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0);
        sample();
        check_eq("rst_mid_stall_pre", d_stall, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_forces_stall0", d_stall, 0);
        tick();
        rst = 1'b0;
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("rst_mid_count", d_count, 0);
        check_eq("rst_mid_stall", d_stall, 0);
        check_eq("rst_mid_fwd", d_fwd, 0);

        // sweep instance: adjacent consumer stalls two cycles, then forwards from S3
        tick();
        set_w(1'b1, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_w(1'b1, 5'd0, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0);
        sample();
        check_eq("w_stall1", w_stall, 1);
        tick();
        sample();
        check_eq("w_stall2", w_stall, 1);
        check_eq("w_count1", w_count, 1);
        tick();
        sample();
        check_eq("w_release", w_stall, 0);
        check_eq("w_count2", w_count, 2);
        tick();
        set_w(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("w_fwd", w_fwd, 6'b001100);

        // second load-use pair drives the 2-bit counter into saturation
        tick();
        set_w(1'b1, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_w(1'b1, 5'd3, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        sample();
        check_eq("w_sat_stall1", w_stall, 1);
        tick();
        sample();
        check_eq("w_sat_stall2", w_stall, 1);
        check_eq("w_count3", w_count, 3);
        tick();
        sample();
        check_eq("w_sat_release", w_stall, 0);
        check_eq("w_count_sat", w_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
